// File: rtl/punch_column_encoder_pkg.sv
// Shared types and row-code helpers for the punch column encoder.
// Rows use IBM 1-origin numbering; row1 maps to the MSB of the 12-bit image.
package punch_column_encoder_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FIRE  = 2'd1,
    ST_REST  = 2'd2
  } state_t;

  localparam int          COL_W    = 12;
  localparam logic [3:0]  ROW_NONE = 4'd0;
  localparam logic [3:0]  ROW_MAX  = 4'd12;

  // Bit position of row k within the column image.
  function automatic logic [3:0] row_bit(input logic [3:0] k);
    return 4'(ROW_MAX - k);
  endfunction

endpackage

// File: rtl/punch_column_encoder_row_decode12.sv
// Combinational row code to one-hot column bit, with a validity flag.
// Codes 0..12 are valid; 0 yields an empty column.
module row_decode12
  import punch_column_encoder_pkg::*;
(
  input  logic [3:0]       code,
  output logic [COL_W-1:0] onehot,
  output logic             valid
);

  always_comb begin
    onehot = '0;
    valid  = (code <= ROW_MAX);
    if ((code != ROW_NONE) && (code <= ROW_MAX)) begin
      onehot[row_bit(code)] = 1'b1;
    end
  end

endmodule

// File: rtl/punch_column_encoder.sv
// Accumulates row codes into a column image and pulses it onto the punch
// magnets for PULSE cycles, followed by a GAP-cycle recovery interval.
module punch_column_encoder
  import punch_column_encoder_pkg::*;
#(
  parameter int PULSE = 8,
  parameter int GAP   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [3:0]       i_code,
  input  logic             i_last,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [COL_W-1:0] o_col,
  output logic             o_fire,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [7:0] PULSE_LD = 8'(PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [COL_W-1:0] image;
  logic [COL_W-1:0] dec_onehot;
  logic             dec_valid;
  logic             first_beat;
  logic             accept;

  row_decode12 u_decode (
    .code   (i_code),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  assign accept = i_valid && (state == ST_ACCUM);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ACCUM: begin
        if (accept && i_last) begin
          state_nxt = ST_FIRE;
          cnt_nxt   = PULSE_LD;
        end
      end
      ST_FIRE: begin
        if (cnt == 8'd0) begin
          state_nxt = (GAP == 0) ? ST_ACCUM : ST_REST;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_REST: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_ACCUM;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_ACCUM;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_ACCUM;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Image is wiped on the way back into ACCUM so no residue reaches the next column.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      image <= '0;
    end else if ((state != ST_ACCUM) && (state_nxt == ST_ACCUM)) begin
      image <= '0;
    end else if (accept) begin
      image <= image | dec_onehot;
    end
  end

  // The error flag survives FIRE/REST and is replaced by the next column's first beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err      <= 1'b0;
      first_beat <= 1'b1;
    end else if (accept) begin
      o_err      <= first_beat ? !dec_valid : (o_err || !dec_valid);
      first_beat <= i_last;
    end
  end

  assign o_ready = (state == ST_ACCUM);
  assign o_fire  = (state == ST_FIRE);
  assign o_busy  = (state != ST_ACCUM);
  assign o_col   = o_fire ? image : '0;

endmodule

// File: tb/tb_punch_column_encoder.sv
// Self-checking bench: two encoder instances (GAP=4 and GAP=0) driven by
// directed and random columns, checked against a column-level timing model.
module tb_punch_column_encoder;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  code;
  logic        last;
  logic        valid;
  logic        sel;
  logic        valid_a, valid_b;
  logic        ready_a, fire_a, busy_a, err_a;
  logic        ready_b, fire_b, busy_b, err_b;
  logic [11:0] col_a, col_b;
  logic        ready_s, fire_s, busy_s, err_s;
  logic [11:0] col_s;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  q_code[$];
  logic        prev_err[2];
  logic [11:0] fired;

  always #5 clk = ~clk;

  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign ready_s = sel ? ready_b : ready_a;
  assign fire_s  = sel ? fire_b  : fire_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign err_s   = sel ? err_b   : err_a;
  assign col_s   = sel ? col_b   : col_a;

  punch_column_encoder #(.PULSE(P), .GAP(4)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(code), .i_last(last), .i_valid(valid_a),
    .o_ready(ready_a), .o_col(col_a), .o_fire(fire_a), .o_busy(busy_a), .o_err(err_a)
  );

  punch_column_encoder #(.PULSE(P), .GAP(0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(code), .i_last(last), .i_valid(valid_b),
    .o_ready(ready_b), .o_col(col_b), .o_fire(fire_b), .o_busy(busy_b), .o_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reads a column back into a row code: first set row from row1 downwards.
  function automatic int prio_enc(input logic [11:0] c);
    for (int r = 1; r <= 12; r++) begin
      if (c[12-r]) return r;
    end
    return 0;
  endfunction

  // Sends q_code as one column to the selected instance and checks the whole
  // ACCUM/FIRE/REST timeline. With hold set, a non-last beat of hold_code is
  // kept on the bus through FIRE/REST; the caller must start the next column with it.
  task automatic run_col(input bit s, input bit hold, input logic [3:0] hold_code,
                         output logic [11:0] fired_col);
    int          g;
    int          n;
    logic [11:0] img;
    logic        bad;
    g   = s ? 0 : 4;
    n   = q_code.size();
    img = '0;
    bad = 1'b0;
    fired_col = '0;
    sel = s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("accum_ready", ready_s, 1);
      chk("accum_busy", busy_s, 0);
      chk("accum_col", col_s, 0);
      chk("accum_err", err_s, (i == 0) ? prev_err[s] : bad);
      code  = q_code[i];
      last  = (i == n - 1);
      valid = 1'b1;
      if (q_code[i] >= 4'd1 && q_code[i] <= 4'd12) img = img | (12'h800 >> (q_code[i] - 4'd1));
      if (q_code[i] > 4'd12) bad = 1'b1;
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (i == 0) begin
        fired_col = col_s;
        if (hold) begin
          code  = hold_code;
          last  = 1'b0;
          valid = 1'b1;
        end else begin
          valid = 1'b0;
          last  = 1'b0;
        end
      end
      chk("fire_fire", fire_s, 1);
      chk("fire_col", col_s, img);
      chk("fire_busy", busy_s, 1);
      chk("fire_ready", ready_s, 0);
      chk("fire_err", err_s, bad);
    end
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      chk("rest_fire", fire_s, 0);
      chk("rest_col", col_s, 0);
      chk("rest_busy", busy_s, 1);
      chk("rest_ready", ready_s, 0);
    end
    prev_err[s] = bad;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    code  = 4'd0;
    last  = 1'b0;
    sel   = 1'b0;
    prev_err[0] = 1'b0;
    prev_err[1] = 1'b0;

    #12;
    chk("rst_ready_a", ready_a, 1);
    chk("rst_col_a", col_a, 0);
    chk("rst_fire_a", fire_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_col_b", col_b, 0);
    chk("rst_busy_b", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round trip
    q_code = '{4'd12, 4'd0, 4'd1};
    run_col(1'b0, 1'b0, 4'd0, fired);
    chk("roundtrip_col", fired, 12'h801);

    // Invalid and duplicate codes, then a clean column
    q_code = '{4'd14, 4'd3, 4'd3};
    run_col(1'b0, 1'b0, 4'd0, fired);
    chk("invalid_col", fired, 12'h200);
    chk("invalid_err", prev_err[0], 1);
    q_code = '{4'd5};
    run_col(1'b0, 1'b0, 4'd0, fired);
    chk("clean_col", fired, 12'h080);

    // Blank column on the GAP=0 instance
    q_code = '{4'd0};
    run_col(1'b1, 1'b0, 4'd0, fired);
    chk("blank_col", fired, 12'h000);

    // Backpressure: code 7 held through FIRE/REST of a column already holding row 7
    q_code = '{4'd7};
    run_col(1'b0, 1'b1, 4'd7, fired);
    chk("bp_prior_col", fired, 12'h020);
    q_code = '{4'd7, 4'd3};
    run_col(1'b0, 1'b0, 4'd0, fired);
    chk("bp_next_col", fired, 12'h220);

    // Backpressure with a distinct held code, on both instances
    for (int t = 0; t < 4; t++) begin
      logic [3:0] hc;
      bit         s;
      hc = 4'($urandom_range(1, 12));
      s  = t[0];
      q_code = '{4'd7};
      run_col(s, 1'b1, hc, fired);
      q_code = '{hc};
      run_col(s, 1'b0, 4'd0, fired);
      chk("bp_rand_enc", prio_enc(fired), hc);
    end

    // Asynchronous reset in the middle of FIRE
    sel = 1'b0;
    @(negedge clk);
    code = 4'd14; last = 1'b0; valid = 1'b1;
    @(negedge clk);
    code = 4'd9; last = 1'b1;
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    @(negedge clk);
    chk("pre_rst_fire", fire_a, 1);
    chk("pre_rst_col", col_a, 12'h008);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_col", col_a, 0);
    chk("async_rst_fire", fire_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_err[0] = 1'b0;
    prev_err[1] = 1'b0;
    q_code = '{4'd4};
    run_col(1'b0, 1'b0, 4'd0, fired);
    chk("post_rst_col", fired, 12'h100);

    // Exhaustive single-row decode, alternating instances
    for (int k = 1; k <= 12; k++) begin
      q_code = '{4'(k)};
      run_col(k[0], 1'b0, 4'd0, fired);
      chk("exh_col", fired, 12'd1 << (12 - k));
      chk("exh_enc", prio_enc(fired), k);
    end

    // Random columns
    for (int t = 0; t < 40; t++) begin
      int nb;
      nb = $urandom_range(1, 5);
      q_code.delete();
      for (int b = 0; b < nb; b++) begin
        q_code.push_back(($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15))
                                                      : 4'($urandom_range(0, 12)));
      end
      run_col(bit'($urandom_range(0, 1)), 1'b0, 4'd0, fired);
    end

    @(negedge clk);
    chk("final_ready_a", ready_a, 1);
    chk("final_busy_b", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
